data_demux_param: RTL and testbench

DATA_DEMUX_PARAM -- requirements
Module: data_demux_param

---
 rtl/data_demux_param.sv | 185 ++++++++++++++++++
 tb/tb_data_demux_param.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_demux_param.sv
// data_demux_param
// Collects Modbus register values addressed to this slave into a staging
// buffer and publishes them to the output channels only once the frame has
// been confirmed good by the CRC checker. A bad frame discards everything
// staged since the last decision. Committing sweeps one channel per clock so
// each channel's update pulse is a clean single-cycle event.

module data_demux_param #(
    parameter logic [7:0] SLAVE_ID    = 8'd1,
    parameter int          NUM_REG     = 30,
    parameter int          FIRST_IDX   = 1,
    parameter int          STALE_LIMIT = 1000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             adr,
    input  logic [7:0]             n_data,
    input  logic [15:0]            data_in,
    input  logic                   data_strb,
    input  logic                   crc_validate,
    input  logic                   crc_error,
    output logic [16*NUM_REG-1:0]  data_out,
    output logic [NUM_REG-1:0]     upd,
    output logic [15:0]            frame_cnt,
    output logic [15:0]            err_cnt,
    output logic                   stale
);

    // Channel index width; a single-channel build still needs one bit.
    localparam int IW = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;

    // Stale counter just wide enough to hold STALE_LIMIT itself.
    localparam int SW_RAW = $clog2(STALE_LIMIT + 1);
    localparam int SW     = (SW_RAW > 0) ? SW_RAW : 1;

    localparam logic [SW-1:0] STALE_MAX = SW'(STALE_LIMIT);
    localparam logic [IW-1:0] LAST_CH   = IW'(NUM_REG - 1);

    // Register index window, 9 bits so FIRST_IDX+NUM_REG-1 never wraps.
    localparam logic [8:0] IDX_LO = 9'(FIRST_IDX);
    localparam logic [8:0] IDX_HI = 9'(FIRST_IDX + NUM_REG - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    state_t                r_state;
    logic [IW-1:0]         r_chIdx;

    logic                  r_strbQ;
    logic                  r_valQ;
    logic                  r_errQ;

    logic [15:0]           r_stage [NUM_REG];
    logic [NUM_REG-1:0]    r_dirty;

    logic [16*NUM_REG-1:0] r_dataOut;
    logic [NUM_REG-1:0]    r_upd;
    logic [15:0]           r_frameCnt;
    logic [15:0]           r_errCnt;
    logic [SW-1:0]         r_staleCnt;

    logic                  w_strbRise;
    logic                  w_valRise;
    logic                  w_errRise;
    logic [8:0]            w_nData9;
    logic                  w_inRange;
    logic [IW-1:0]         w_relIdx;
    logic                  w_strbAccept;
    logic                  w_commitDone;

    assign w_strbRise = data_strb    & ~r_strbQ;
    assign w_valRise  = crc_validate & ~r_valQ;
    assign w_errRise  = crc_error    & ~r_errQ;

    assign w_nData9  = {1'b0, n_data};
    assign w_inRange = (w_nData9 >= IDX_LO) && (w_nData9 <= IDX_HI);
    assign w_relIdx  = IW'(w_nData9 - IDX_LO);

    // Staging is only open between frames; writes arriving mid-sweep belong
    // to no frame we can still decide on, so they are dropped.
    assign w_strbAccept = w_strbRise && (r_state == ST_IDLE) &&
                          (adr == SLAVE_ID) && w_inRange;

    assign w_commitDone = (r_state == ST_COMMIT) && (r_chIdx == LAST_CH);

    assign data_out  = r_dataOut;
    assign upd       = r_upd;
    assign frame_cnt = r_frameCnt;
    assign err_cnt   = r_errCnt;
    assign stale     = (r_staleCnt == STALE_MAX);

    // Remember last-cycle input levels so only rising edges act.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_strbQ <= 1'b0;
            r_valQ  <= 1'b0;
            r_errQ  <= 1'b0;
        end else begin
            r_strbQ <= data_strb;
            r_valQ  <= crc_validate;
            r_errQ  <= crc_error;
        end
    end

    // Capture accepted register writes; a repeat write simply overwrites.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_REG; k++) begin
                r_stage[k] <= '0;
            end
        end else if (w_strbAccept) begin
            r_stage[w_relIdx] <= data_in;
        end
    end

    // Frame decision FSM: IDLE tracks dirty channels and waits for the CRC
    // verdict, COMMIT walks every channel once and publishes the dirty ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_chIdx    <= '0;
            r_dirty    <= '0;
            r_dataOut  <= '0;
            r_upd      <= '0;
            r_frameCnt <= '0;
            r_errCnt   <= '0;
        end else begin
            r_upd <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_errRise) begin
                        // Bad frame wins even if validate rose in the same
                        // cycle; everything staged so far is discarded.
                        r_dirty <= '0;
                        if (r_errCnt != 16'hFFFF) begin
                            r_errCnt <= r_errCnt + 16'd1;
                        end
                    end else begin
                        if (w_strbAccept) begin
                            r_dirty[w_relIdx] <= 1'b1;
                        end
                        if (w_valRise) begin
                            r_state <= ST_COMMIT;
                            r_chIdx <= '0;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (r_dirty[r_chIdx]) begin
                        r_dataOut[{r_chIdx, 4'b0000} +: 16] <= r_stage[r_chIdx];
                        r_dirty[r_chIdx]                    <= 1'b0;
                        r_upd[r_chIdx]                      <= 1'b1;
                    end
                    if (r_chIdx == LAST_CH) begin
                        r_state <= ST_IDLE;
                        r_chIdx <= '0;
                        if (r_frameCnt != 16'hFFFF) begin
                            r_frameCnt <= r_frameCnt + 16'd1;
                        end
                    end else begin
                        r_chIdx <= r_chIdx + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_chIdx <= '0;
                end
            endcase
        end
    end

    // Age since the last completed commit; comes out of reset already stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_staleCnt <= STALE_MAX;
        end else if (w_commitDone) begin
            r_staleCnt <= '0;
        end else if (r_staleCnt != STALE_MAX) begin
            r_staleCnt <= r_staleCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_data_demux_param.sv
// Testbench for data_demux_param: directed steps drive Modbus-style writes and
// CRC verdicts, a small model predicts channel contents and queues the
// expected update pulses, and a monitor pops them as the DUT pulses upd.

module tb_data_demux_param;

    localparam int NR = 30;
    localparam int SL = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       adr = '0;
    logic [7:0]       n_data = '0;
    logic [15:0]      data_in = '0;
    logic             data_strb = 1'b0;
    logic             crc_validate = 1'b0;
    logic             crc_error = 1'b0;
    logic [16*NR-1:0] data_out;
    logic [NR-1:0]    upd;
    logic [15:0]      frame_cnt;
    logic [15:0]      err_cnt;
    logic             stale;

    data_demux_param #(
        .SLAVE_ID    (8'd1),
        .NUM_REG     (NR),
        .FIRST_IDX   (1),
        .STALE_LIMIT (SL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .adr          (adr),
        .n_data       (n_data),
        .data_in      (data_in),
        .data_strb    (data_strb),
        .crc_validate (crc_validate),
        .crc_error    (crc_error),
        .data_out     (data_out),
        .upd          (upd),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt),
        .stale        (stale)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int          chan;
        logic [15:0] val;
        int          cyc;
    } exp_t;

    exp_t expQ[$];

    logic [15:0] mStage [NR];
    bit          mDirty [NR];
    logic [15:0] mOut   [NR];
    int          mFrame = 0;
    int          mErr = 0;

    typedef enum {OP_WRITE, OP_VALID, OP_ERROR, OP_BOTH} op_t;

    // Every upd pulse must match the oldest queued expectation in channel,
    // cycle and published value; a pulse with nothing queued is an error.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [NR-1:0] oh;
        if (upd !== '0) begin
            total++;
            assert (expQ.size() != 0) else begin
                bad++;
                $error("[TB] FAIL updUnexpected observed upd=%h cyc=%0d expected no pulse", upd, cyc);
            end
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                oh = '0;
                oh[e.chan] = 1'b1;
                total++;
                assert (upd === oh && cyc == e.cyc && data_out[e.chan*16 +: 16] === e.val) else begin
                    bad++;
                    $error("[TB] FAIL updPulse observed upd=%h cyc=%0d data=%h expected upd=%h cyc=%0d data=%h",
                           upd, cyc, data_out[e.chan*16 +: 16], oh, e.cyc, e.val);
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        #1;
        for (int k = 0; k < NR; k++) begin
            checkOutput($sformatf("%s_ch%0d", tag, k), {16'd0, data_out[k*16 +: 16]}, {16'd0, mOut[k]});
        end
        checkOutput({tag, "_frame"}, {16'd0, frame_cnt}, mFrame);
        checkOutput({tag, "_err"}, {16'd0, err_cnt}, mErr);
        checkOutput({tag, "_queue"}, expQ.size(), 0);
    endtask

    task automatic modelReset();
        for (int k = 0; k < NR; k++) begin
            mStage[k] = '0;
            mDirty[k] = 1'b0;
            mOut[k]   = '0;
        end
        mFrame = 0;
        mErr = 0;
    endtask

    // Queue the pulses a commit starting at edge e0 should produce, for
    // channels below chanLimit, and update the model outputs.
    task automatic predictCommit(input int e0, input int chanLimit);
        exp_t e;
        for (int k = 0; k < NR; k++) begin
            if (mDirty[k] && k < chanLimit) begin
                e.chan = k;
                e.val  = mStage[k];
                e.cyc  = e0 + 1 + k;
                expQ.push_back(e);
                mOut[k]   = mStage[k];
                mDirty[k] = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input op_t op, input logic [7:0] a, input logic [7:0] n,
                                 input logic [15:0] d, input bit noise);
        int e0;
        @(negedge clk);
        case (op)
            OP_WRITE: begin
                adr = a;
                n_data = n;
                data_in = d;
                data_strb = 1'b1;
                @(negedge clk);
                data_strb = 1'b0;
                if (a == 8'd1 && n >= 1 && n <= NR) begin
                    mStage[n-1] = d;
                    mDirty[n-1] = 1'b1;
                end
            end
            OP_ERROR, OP_BOTH: begin
                crc_error = 1'b1;
                crc_validate = (op == OP_BOTH);
                @(negedge clk);
                crc_error = 1'b0;
                crc_validate = 1'b0;
                for (int k = 0; k < NR; k++) mDirty[k] = 1'b0;
                if (mErr < 65535) mErr++;
            end
            OP_VALID: begin
                crc_validate = 1'b1;
                e0 = cyc + 1;
                predictCommit(e0, NR);
                if (mFrame < 65535) mFrame++;
                @(negedge clk);
                crc_validate = 1'b0;
                for (int i = 0; i < NR; i++) begin
                    if (noise && i == 4) begin
                        crc_error = 1'b1;
                        adr = 8'd1;
                        n_data = 8'd9;
                        data_in = 16'h9999;
                        data_strb = 1'b1;
                    end
                    if (noise && i == 5) begin
                        crc_error = 1'b0;
                        data_strb = 1'b0;
                        crc_validate = 1'b1;
                    end
                    if (noise && i == 6) crc_validate = 1'b0;
                    @(negedge clk);
                end
                #1;
            end
            default: ;
        endcase
    endtask

    initial begin : stimulus
        int e0;
        modelReset();

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_upd", {2'b0, upd}, 32'd0);
        checkOutput("rst_stale", {31'd0, stale}, 32'd1);
        checkAll("rst");
        @(negedge clk);
        reset = 1'b0;

        // Basic commit of first and last channel
        applyStimulus(OP_WRITE, 8'd1, 8'd1, 16'h1234, 1'b0);
        applyStimulus(OP_WRITE, 8'd1, 8'd30, 16'hBEEF, 1'b0);
        #1;
        checkOutput("preCommit_stale", {31'd0, stale}, 32'd1);
        applyStimulus(OP_VALID, 8'd0, 8'd0, 16'd0, 1'b0);
        checkOutput("commit1_stale", {31'd0, stale}, 32'd0);
        checkAll("commit1");

        // Stale asserts exactly STALE_LIMIT clocks after completion
        repeat (SL - 1) @(negedge clk);
        #1;
        checkOutput("idle15_stale", {31'd0, stale}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("idle16_stale", {31'd0, stale}, 32'd1);

        // Wrong address and out-of-range indices are ignored
        applyStimulus(OP_WRITE, 8'd2, 8'd5, 16'hAAAA, 1'b0);
        applyStimulus(OP_WRITE, 8'd1, 8'd0, 16'hC0C0, 1'b0);
        applyStimulus(OP_WRITE, 8'd1, 8'd31, 16'hD0D0, 1'b0);
        applyStimulus(OP_VALID, 8'd0, 8'd0, 16'd0, 1'b0);
        checkOutput("commit2_stale", {31'd0, stale}, 32'd0);
        checkAll("ignored");

        // Last write to a channel wins
        applyStimulus(OP_WRITE, 8'd1, 8'd3, 16'h1111, 1'b0);
        applyStimulus(OP_WRITE, 8'd1, 8'd3, 16'h2222, 1'b0);
        applyStimulus(OP_VALID, 8'd0, 8'd0, 16'd0, 1'b0);
        checkAll("overwrite");

        // CRC error discards staged data
        applyStimulus(OP_WRITE, 8'd1, 8'd4, 16'h5555, 1'b0);
        applyStimulus(OP_ERROR, 8'd0, 8'd0, 16'd0, 1'b0);
        applyStimulus(OP_VALID, 8'd0, 8'd0, 16'd0, 1'b0);
        checkAll("crcErr");

        // Simultaneous validate and error counts as error only
        applyStimulus(OP_WRITE, 8'd1, 8'd6, 16'h6666, 1'b0);
        applyStimulus(OP_BOTH, 8'd0, 8'd0, 16'd0, 1'b0);
        #1;
        checkOutput("both_frame", {16'd0, frame_cnt}, mFrame);
        checkOutput("both_err", {16'd0, err_cnt}, mErr);
        applyStimulus(OP_VALID, 8'd0, 8'd0, 16'd0, 1'b0);
        checkAll("both");

        // Writes, errors and validates during a sweep are ignored
        applyStimulus(OP_WRITE, 8'd1, 8'd8, 16'h7878, 1'b0);
        applyStimulus(OP_VALID, 8'd0, 8'd0, 16'd0, 1'b1);
        checkAll("noise");
        applyStimulus(OP_VALID, 8'd0, 8'd0, 16'd0, 1'b0);
        checkAll("noiseAfter");

        // Reset in the middle of a sweep
        applyStimulus(OP_WRITE, 8'd1, 8'd1, 16'h1111, 1'b0);
        applyStimulus(OP_WRITE, 8'd1, 8'd10, 16'hA0A0, 1'b0);
        applyStimulus(OP_WRITE, 8'd1, 8'd21, 16'h2121, 1'b0);
        @(negedge clk);
        crc_validate = 1'b1;
        e0 = cyc + 1;
        predictCommit(e0, 10);
        @(negedge clk);
        crc_validate = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("midRst_upd", {2'b0, upd}, 32'd0);
        checkOutput("midRst_stale", {31'd0, stale}, 32'd1);
        checkAll("midRst");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (NR + 2) @(negedge clk);
        checkAll("postRst");

        // Normal operation resumes after reset
        applyStimulus(OP_VALID, 8'd0, 8'd0, 16'd0, 1'b0);
        checkAll("resumeEmpty");
        applyStimulus(OP_WRITE, 8'd1, 8'd6, 16'h7777, 1'b0);
        applyStimulus(OP_VALID, 8'd0, 8'd0, 16'd0, 1'b0);
        checkAll("resume");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
